// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and sizing helpers for the RAM responder slice.
//   zustand_t    - transaction state of the responder
//   WORTBITS     - data word width of the RAM port and backing store
//   words_f      - beats per block for a given BLOCKSIZEBITS
//   beat_bits_f  - beat counter width for a given BLOCKSIZEBITS (at least 1)
// ---------------------------------------------------------------------------
package ram_pkg;

    localparam int WORTBITS = 32;

    typedef enum logic [2:0] {
        LEERLAUF,
        WARTEN,
        LESEN,
        SCHREIBEN,
        FERTIG
    } zustand_t;

    // A block of 2^blocksizebits bytes holds 2^(blocksizebits-2) 32-bit words.
    function automatic int words_f(input int blocksizebits);
        return 1 << (blocksizebits - 2);
    endfunction

    // A one-word block still needs a 1-bit counter so the vector is legal.
    function automatic int beat_bits_f(input int blocksizebits);
        return (blocksizebits - 2 < 1) ? 1 : blocksizebits - 2;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// ---------------------------------------------------------------------------
// ram_responder_if
// Block-transfer port between the cache (master) and the RAM responder
// (slave).
//   RAMAnfrage        cache -> ram   request, held until RAMAngenommen
//   RAMSchreiben      cache -> ram   1 = block write, 0 = block read
//   RAMAdresse        cache -> ram   byte address of the block
//   RAMSchreibDaten   cache -> ram   write beat data
//   RAMSchreibGueltig cache -> ram   write beat valid
//   RAMAngenommen     ram -> cache   one-cycle pulse, request accepted
//   RAMLesDaten       ram -> cache   read beat data
//   RAMLesGueltig     ram -> cache   read beat valid
//   RAMSchreibBereit  ram -> cache   ready for a write beat
//   RAMFertig         ram -> cache   one-cycle pulse, transaction complete
//   RAMBeschaeftigt   ram -> cache   responder busy
// ---------------------------------------------------------------------------
interface ram_responder_if;
    import ram_pkg::*;

    logic                RAMAnfrage;
    logic                RAMSchreiben;
    logic [31:0]         RAMAdresse;
    logic [WORTBITS-1:0] RAMSchreibDaten;
    logic                RAMSchreibGueltig;
    logic                RAMAngenommen;
    logic [WORTBITS-1:0] RAMLesDaten;
    logic                RAMLesGueltig;
    logic                RAMSchreibBereit;
    logic                RAMFertig;
    logic                RAMBeschaeftigt;

    modport master (
        output RAMAnfrage, RAMSchreiben, RAMAdresse, RAMSchreibDaten, RAMSchreibGueltig,
        input  RAMAngenommen, RAMLesDaten, RAMLesGueltig, RAMSchreibBereit, RAMFertig,
               RAMBeschaeftigt
    );

    modport slave (
        input  RAMAnfrage, RAMSchreiben, RAMAdresse, RAMSchreibDaten, RAMSchreibGueltig,
        output RAMAngenommen, RAMLesDaten, RAMLesGueltig, RAMSchreibBereit, RAMFertig,
               RAMBeschaeftigt
    );

endinterface

// File: rtl/ram_speicher.sv
// ---------------------------------------------------------------------------
// ram_speicher
// Single-port synchronous backing store, 2^ADDRBITS words of WORTBITS bits.
//   Takt            clock, rising edge
//   Zuruecksetzen_n asynchronous active-low reset (read register only)
//   schreiben       write enable, stores schreib_daten at adresse
//   lesen           read enable, loads les_daten from adresse
//   adresse         word address shared by read and write
//   schreib_daten   write data
//   les_daten       registered read data, holds when lesen is low
// ---------------------------------------------------------------------------
module ram_speicher
    import ram_pkg::*;
#(
    parameter int ADDRBITS = 12
) (
    input  logic                Takt,
    input  logic                Zuruecksetzen_n,
    input  logic                schreiben,
    input  logic                lesen,
    input  logic [ADDRBITS-1:0] adresse,
    input  logic [WORTBITS-1:0] schreib_daten,
    output logic [WORTBITS-1:0] les_daten
);

    logic [WORTBITS-1:0] feld [2**ADDRBITS];

    // NOTE: the array has no reset; contents must survive a reset and a
    // resettable array would not map onto block RAM.
    always_ff @(posedge Takt) begin
        if (schreiben) begin
            feld[adresse] <= schreib_daten;
        end
    end

    always_ff @(posedge Takt or negedge Zuruecksetzen_n) begin
        if (!Zuruecksetzen_n) begin
            les_daten <= '0;
        end else if (lesen) begin
            les_daten <= feld[adresse];
        end
    end

endmodule

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
// Memory-side responder for the cache RAM port. Accepts one block request at
// a time, waits LATENZ extra cycles, then streams (read) or accepts (write)
// one word per beat in ascending address order from an on-chip store.
//   Takt            clock, rising edge
//   Zuruecksetzen_n asynchronous active-low reset, aborts any transaction
//   bus             ram_responder_if.slave, block transfer port
// Parameters:
//   ADDRBITS        word-address width of the store (2^ADDRBITS words)
//   BLOCKSIZEBITS   log2 of block size in bytes (2..ADDRBITS+2)
//   LATENZ          extra wait cycles between acceptance and first beat
// ---------------------------------------------------------------------------
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDRBITS      = 12,
    parameter int BLOCKSIZEBITS = 5,
    parameter int LATENZ        = 3
) (
    input  logic           Takt,
    input  logic           Zuruecksetzen_n,
    ram_responder_if.slave bus
);

    localparam int                  WORDS     = words_f(BLOCKSIZEBITS);
    localparam int                  BB        = beat_bits_f(BLOCKSIZEBITS);
    localparam int                  LB        = (LATENZ < 1) ? 1 : $clog2(LATENZ + 1);
    localparam logic [ADDRBITS-1:0] OFFS_MASK = ADDRBITS'(WORDS - 1);
    localparam logic [BB-1:0]       LAST_BEAT = BB'(WORDS - 1);

    zustand_t            zustand;
    zustand_t            zustand_next;
    logic [ADDRBITS-1:0] basis;
    logic                schreib_richtung;
    logic [BB-1:0]       beat;
    logic [LB-1:0]       latenz_cnt;
    logic                angenommen_q;

    logic                letzter_beat;
    logic                bereit;
    logic                fertig;
    logic                beat_nehmen;
    logic                speicher_lesen;
    logic [BB-1:0]       zeiger;
    logic [ADDRBITS-1:0] speicher_adresse;
    logic [WORTBITS-1:0] les_daten;

    // Address bits outside the word index are ignored (byte offset, wrap).
    logic unused_adresse;
    assign unused_adresse = ^bus.RAMAdresse;

    assign letzter_beat = (beat == LAST_BEAT);
    assign beat_nehmen  = bereit && bus.RAMSchreibGueltig;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge Takt or negedge Zuruecksetzen_n) begin
        if (!Zuruecksetzen_n) begin
            zustand <= LEERLAUF;
        end else begin
            zustand <= zustand_next;
        end
    end

    // WARTEN lasts LATENZ+1 cycles. Its last cycle already issues the first
    // store read (data appears with the first LESEN cycle) and already
    // offers write beat 0, so both directions see the same latency.
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        zustand_next   = zustand;
        bereit         = 1'b0;
        fertig         = 1'b0;
        speicher_lesen = 1'b0;
        zeiger         = beat;
        case (zustand)
            LEERLAUF: begin
                if (bus.RAMAnfrage) begin
                    zustand_next = WARTEN;
                end
            end
            WARTEN: begin
                if (latenz_cnt == '0) begin
                    if (schreib_richtung) begin
                        bereit       = 1'b1;
                        zustand_next = (bus.RAMSchreibGueltig && letzter_beat) ? FERTIG : SCHREIBEN;
                    end else begin
                        speicher_lesen = 1'b1;
                        zustand_next   = LESEN;
                    end
                end
            end
            LESEN: begin
                // Beat k is on the output; fetch word k+1 for the next cycle.
                fertig         = letzter_beat;
                speicher_lesen = !letzter_beat;
                zeiger         = beat + 1'b1;
                if (letzter_beat) begin
                    zustand_next = LEERLAUF;
                end
            end
            SCHREIBEN: begin
                bereit = 1'b1;
                if (bus.RAMSchreibGueltig && letzter_beat) begin
                    zustand_next = FERTIG;
                end
            end
            FERTIG: begin
                fertig       = 1'b1;
                zustand_next = LEERLAUF;
            end
            default: begin
                zustand_next = LEERLAUF;
            end
        endcase
    end

    always_ff @(posedge Takt or negedge Zuruecksetzen_n) begin
        if (!Zuruecksetzen_n) begin
            basis            <= '0;
            schreib_richtung <= 1'b0;
            beat             <= '0;
            latenz_cnt       <= '0;
            angenommen_q     <= 1'b0;
        end else begin
            angenommen_q <= (zustand == LEERLAUF) && bus.RAMAnfrage;
            case (zustand)
                LEERLAUF: begin
                    if (bus.RAMAnfrage) begin
                        basis            <= bus.RAMAdresse[ADDRBITS+1:2] & ~OFFS_MASK;
                        schreib_richtung <= bus.RAMSchreiben;
                        latenz_cnt       <= LB'(LATENZ);
                        beat             <= '0;
                    end
                end
                WARTEN: begin
                    if (latenz_cnt != '0) begin
                        latenz_cnt <= latenz_cnt - 1'b1;
                    end else if (beat_nehmen) begin
                        beat <= beat + 1'b1;
                    end
                end
                LESEN: begin
                    beat <= beat + 1'b1;
                end
                SCHREIBEN: begin
                    if (beat_nehmen) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beats stay inside the block: only the offset bits take the counter.
    assign speicher_adresse = basis | (ADDRBITS'(zeiger) & OFFS_MASK);

    ram_speicher #(
        .ADDRBITS (ADDRBITS)
    ) u_speicher (
        .Takt            (Takt),
        .Zuruecksetzen_n (Zuruecksetzen_n),
        .schreiben       (beat_nehmen),
        .lesen           (speicher_lesen),
        .adresse         (speicher_adresse),
        .schreib_daten   (bus.RAMSchreibDaten),
        .les_daten       (les_daten)
    );

    assign bus.RAMAngenommen    = angenommen_q;
    assign bus.RAMLesDaten      = les_daten;
    assign bus.RAMLesGueltig    = (zustand == LESEN);
    assign bus.RAMSchreibBereit = bereit;
    assign bus.RAMFertig        = fertig;
    assign bus.RAMBeschaeftigt  = (zustand != LEERLAUF);

endmodule
